// File: rtl/mem_arbiter.sv
// Purpose: round-robin sharing of one single-port memory between fetch and data ports.
// Latency: grant in IDLE at t -> strobe at t+1, write valid at t+2, read valid at t+2+MEM_LAT.
// Backpressure: one transaction in flight; a competing request is held off by its own req level.
//
// Ports:
//   clock, reset            rising-edge clock, async active-low reset
//   if_req/if_addr          fetch request (level) and address
//   if_rdata/if_valid       fetched word and one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata   data request, store select, address, store data
//   d_rdata/d_valid         load data and one-cycle completion pulse
//   mem_addr/mem_wdata/mem_re/mem_we/mem_rdata   memory side, read data MEM_LAT after mem_re
//   busy                    high whenever a transaction is being serviced
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // The wait counter only ever holds MEM_LAT-1 down to 0.
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LAT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             owner_data;    // 1 = data port owns the current transaction
    logic             is_write;      // current transaction is a store
    logic             rr_last_data;  // 1 = data port was served last
    logic             grant_data;

    // Data wins when it is the only requester, or when both request and
    // fetch was served last. Only feeds registers, never mem_* directly.
    assign grant_data = d_req && (!if_req || !rr_last_data);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            owner_data   <= 1'b0;
            is_write     <= 1'b0;
            rr_last_data <= 1'b0;   // "fetch served last" makes data win the first tie
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_re       <= 1'b0;
            mem_we       <= 1'b0;
            if_rdata     <= '0;
            if_valid     <= 1'b0;
            d_rdata      <= '0;
            d_valid      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            // Strobes and completion pulses are single-cycle by default.
            mem_re   <= 1'b0;
            mem_we   <= 1'b0;
            if_valid <= 1'b0;
            d_valid  <= 1'b0;

            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        owner_data <= grant_data;
                        is_write   <= grant_data && d_we;
                        mem_addr   <= grant_data ? d_addr : if_addr;
                        // Fetches never write; keep the write bus quiet for them.
                        mem_wdata  <= grant_data ? d_wdata : '0;
                        mem_re     <= !(grant_data && d_we);
                        mem_we     <= grant_data && d_we;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (is_write) begin
                        d_valid <= owner_data;
                        if_valid <= 1'b0;
                        state   <= DONE;
                    end else begin
                        cnt   <= LAT_INIT;
                        state <= WAIT;
                    end
                end

                WAIT: begin
                    // cnt reaches zero in the cycle mem_rdata is valid.
                    if (cnt == '0) begin
                        if (owner_data) begin
                            d_rdata <= mem_rdata;
                            d_valid <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_valid <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                DONE: begin
                    rr_last_data <= owner_data;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT0 = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    // Index 0: MEM_LAT=2 (model-checked), 1: MEM_LAT=1, 2: MEM_LAT=5.
    logic          if_req    [3];
    logic [AW-1:0] if_addr   [3];
    logic [DW-1:0] if_rdata  [3];
    logic          if_valid  [3];
    logic          d_req     [3];
    logic          d_we      [3];
    logic [AW-1:0] d_addr    [3];
    logic [DW-1:0] d_wdata   [3];
    logic [DW-1:0] d_rdata   [3];
    logic          d_valid   [3];
    logic [AW-1:0] mem_addr  [3];
    logic [DW-1:0] mem_wdata [3];
    logic          mem_re    [3];
    logic          mem_we    [3];
    logic [DW-1:0] mem_rdata [3];
    logic          busy      [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_arbiter #(
            .ADDR_W (AW),
            .DATA_W (DW),
            .MEM_LAT(g == 0 ? 2 : (g == 1 ? 1 : 5))
        ) u_dut (
            .clock    (clock),
            .reset    (reset),
            .if_req   (if_req[g]),
            .if_addr  (if_addr[g]),
            .if_rdata (if_rdata[g]),
            .if_valid (if_valid[g]),
            .d_req    (d_req[g]),
            .d_we     (d_we[g]),
            .d_addr   (d_addr[g]),
            .d_wdata  (d_wdata[g]),
            .d_rdata  (d_rdata[g]),
            .d_valid  (d_valid[g]),
            .mem_addr (mem_addr[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_re   (mem_re[g]),
            .mem_we   (mem_we[g]),
            .mem_rdata(mem_rdata[g]),
            .busy     (busy[g])
        );
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 5);
    endfunction

    // Memory: stores land in an associative array; unwritten words have a
    // fixed address-derived pattern. Read data is valid only in the cycle
    // exactly MEM_LAT after mem_re, garbage in every other cycle.
    logic [DW-1:0] store [logic [AW-1:0]];

    function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
        if (store.exists(a)) return store[a];
        if (a == 32'h0000_0010) return 32'h0050_0093;
        return {a[15:0], ~a[15:0]};
    endfunction

    int            rd_due  [3];
    logic [AW-1:0] rd_addr [3];

    always @(negedge clock) begin
        for (int k = 0; k < 3; k++) begin
            mem_rdata[k] = (cyc == rd_due[k]) ? mem_read(rd_addr[k]) : (32'hBAD0_0000 | DW'(cyc[15:0]));
            if (mem_re[k]) begin
                rd_due[k]  = cyc + lat_of(k);
                rd_addr[k] = mem_addr[k];
            end
            if (mem_we[k]) store[mem_addr[k]] = mem_wdata[k];
        end
    end

    // Transaction-level model for instance 0: on each grant it schedules the
    // strobe cycle and completion cycle, then every cycle compares outputs.
    bit            m_act = 1'b0;
    bit            m_own_d;
    bit            m_rd;
    bit            m_last_d = 1'b0;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    int            m_issue = 0;
    int            m_done = 0;
    int            m_free = 0;
    logic [DW-1:0] e_ifr = '0;
    logic [DW-1:0] e_dr = '0;
    logic          in_txn;

    always @(negedge clock) begin
        if (!reset) begin
            check("rst_busy", busy[0], 1'b0);
            check("rst_mem_re", mem_re[0], 1'b0);
            check("rst_mem_we", mem_we[0], 1'b0);
            check("rst_if_valid", if_valid[0], 1'b0);
            check("rst_d_valid", d_valid[0], 1'b0);
            check("rst_if_rdata", if_rdata[0], '0);
            check("rst_d_rdata", d_rdata[0], '0);
            check("rst_mem_addr", mem_addr[0], '0);
            m_act    = 1'b0;
            m_last_d = 1'b0;
            e_ifr    = '0;
            e_dr     = '0;
            m_free   = cyc + 1;
        end else begin
            if (!m_act && cyc >= m_free && (if_req[0] || d_req[0])) begin
                m_own_d = d_req[0] && (!if_req[0] || !m_last_d);
                m_rd    = !(m_own_d && d_we[0]);
                m_addr  = m_own_d ? d_addr[0] : if_addr[0];
                m_wdata = d_wdata[0];
                m_issue = cyc + 1;
                m_done  = cyc + 2 + (m_rd ? LAT0 : 0);
                m_act   = 1'b1;
            end
            in_txn = m_act && cyc >= m_issue && cyc <= m_done;
            if (m_act && cyc == m_done && m_rd) begin
                if (m_own_d) e_dr = mem_read(m_addr);
                else         e_ifr = mem_read(m_addr);
            end
            check("busy", busy[0], in_txn);
            check("mem_re", mem_re[0], m_act && m_rd && cyc == m_issue);
            check("mem_we", mem_we[0], m_act && !m_rd && cyc == m_issue);
            check("if_valid", if_valid[0], m_act && !m_own_d && cyc == m_done);
            check("d_valid", d_valid[0], m_act && m_own_d && cyc == m_done);
            check("if_rdata", if_rdata[0], e_ifr);
            check("d_rdata", d_rdata[0], e_dr);
            if (in_txn) begin
                check("mem_addr", mem_addr[0], m_addr);
                if (!m_rd) check("mem_wdata", mem_wdata[0], m_wdata);
            end
            if (m_act && cyc == m_done) begin
                m_act    = 1'b0;
                m_last_d = m_own_d;
                m_free   = cyc + 1;
            end
        end
    end

    // Completion order seen on instance 0: 1 = data, 0 = fetch.
    int dut_order [$];
    always @(negedge clock) begin
        if (reset) begin
            if (d_valid[0])  dut_order.push_back(1);
            if (if_valid[0]) dut_order.push_back(0);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_lat(input int k, input logic [AW-1:0] addr, input logic [DW-1:0] exp_data);
        int t0;
        int lat;
        lat = lat_of(k);
        if_req[k]  = 1'b1;
        if_addr[k] = addr;
        t0 = cyc;
        for (int i = 1; i <= lat + 3; i++) begin
            tick();
            check($sformatf("lat%0d_mem_re", lat), mem_re[k], cyc == t0 + 1);
            check($sformatf("lat%0d_if_valid", lat), if_valid[k], cyc == t0 + 2 + lat);
            if (cyc == t0 + 2 + lat) begin
                check($sformatf("lat%0d_if_rdata", lat), if_rdata[k], exp_data);
                if_req[k] = 1'b0;
            end
        end
    endtask

    int t;
    int n;
    int exp_ord [6] = '{1, 0, 1, 0, 1, 0};

    initial begin
        for (int k = 0; k < 3; k++) begin
            if_req[k] = 1'b0; if_addr[k] = '0;
            d_req[k] = 1'b0;  d_we[k] = 1'b0;
            d_addr[k] = '0;   d_wdata[k] = '0;
            mem_rdata[k] = '0;
            rd_due[k] = -1;   rd_addr[k] = '0;
        end
        tick(); tick(); tick();

        // 1: single fetch straight out of reset
        reset = 1'b1;
        if_req[0] = 1'b1; if_addr[0] = 32'h0000_0010;
        t = cyc;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("t1_mem_re", mem_re[0], i == 1);
            check("t1_if_valid", if_valid[0], i == 4);
            check("t1_d_valid", d_valid[0], 1'b0);
            if (i == 4) begin
                check("t1_if_rdata", if_rdata[0], 32'h0050_0093);
                if_req[0] = 1'b0;
            end
        end

        // 2: simultaneous requests, data wins, fetch follows
        if_req[0] = 1'b1; if_addr[0] = 32'h0000_0020;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h0000_0100;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("t2_mem_re", mem_re[0], i == 1 || i == 6);
            check("t2_d_valid", d_valid[0], i == 4);
            check("t2_if_valid", if_valid[0], i == 9);
            if (i == 4) begin
                check("t2_d_rdata", d_rdata[0], 32'h0100_FEFF);
                d_req[0] = 1'b0;
            end
            if (i == 9) begin
                check("t2_if_rdata", if_rdata[0], 32'h0020_FFDF);
                if_req[0] = 1'b0;
            end
        end

        // 3: both held for six grants -> strict alternation
        dut_order.delete();
        if_req[0] = 1'b1; if_addr[0] = 32'h0000_0024;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h0000_0104;
        n = 0;
        for (int i = 0; i < 60 && n < 6; i++) begin
            tick();
            if (if_valid[0] || d_valid[0]) n++;
        end
        if_req[0] = 1'b0; d_req[0] = 1'b0;
        check("t3_grant_count", n, 6);
        tick(); tick();
        check("t3_order_len", dut_order.size(), 6);
        for (int i = 0; i < 6 && i < dut_order.size(); i++)
            check($sformatf("t3_order_%0d", i), dut_order[i], exp_ord[i]);

        // 4: store, then load it back
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h0000_0200; d_wdata[0] = 32'hDEAD_BEEF;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("t4_mem_we", mem_we[0], i == 1);
            check("t4_mem_re", mem_re[0], 1'b0);
            check("t4_d_valid", d_valid[0], i == 2);
            check("t4_d_rdata", d_rdata[0], 32'h0104_FEFB);
            if (i == 1) begin
                check("t4_mem_addr", mem_addr[0], 32'h0000_0200);
                check("t4_mem_wdata", mem_wdata[0], 32'hDEAD_BEEF);
            end
            if (i == 2) d_req[0] = 1'b0;
        end
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h0000_0200;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("t4_rb_d_valid", d_valid[0], i == 4);
            if (i == 4) begin
                check("t4_rb_d_rdata", d_rdata[0], 32'hDEAD_BEEF);
                d_req[0] = 1'b0;
            end
        end

        // 5: reset during WAIT of a fetch; data must win after release
        if_req[0] = 1'b1; if_addr[0] = 32'h0000_0030;
        tick(); tick();
        check("t5_busy_in_wait", busy[0], 1'b1);
        reset = 1'b0;
        #1;
        check("t5_async_busy", busy[0], 1'b0);
        check("t5_async_d_rdata", d_rdata[0], '0);
        check("t5_async_mem_addr", mem_addr[0], '0);
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h0000_0108;
        tick(); tick();
        reset = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("t5_d_valid", d_valid[0], i == 4);
            check("t5_if_valid", if_valid[0], i == 9);
            if (i == 4) begin
                check("t5_d_rdata", d_rdata[0], 32'h0108_FEF7);
                d_req[0] = 1'b0;
            end
            if (i == 9) begin
                check("t5_if_rdata", if_rdata[0], 32'h0030_FFCF);
                if_req[0] = 1'b0;
            end
        end

        // 6: other latency builds
        run_lat(1, 32'h0000_0040, 32'h0040_FFBF);
        run_lat(2, 32'h0000_0044, 32'h0044_FFBB);

        tick(); tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
